// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for the MEM stage.
// It serves byte, half and word loads and stores, and it handles flush and misaligned accesses.
module data_mem_responder #(
    parameter int unsigned WORD_ADDR_BITS = 10,
    parameter int unsigned WAIT_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        require_mem_access,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_to_mem,
    output logic        data_mem_ready_n,
    output logic [31:0] data_from_mem,
    output logic        access_err
);
    localparam int unsigned AW = WORD_ADDR_BITS + 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, next_state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [1:0]    req_size;
    logic [31:0]   req_data;
    logic [31:0]   mem [1 << WORD_ADDR_BITS];

    logic [AW-1:0] cur_addr;
    logic          cur_write;
    logic [1:0]    cur_size;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic          mem_we;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^addr[31:AW];

    function automatic logic is_improper(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return lane != 2'b00;
            2'b01:   return lane[0];
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        if (is_improper(sz, lane)) return '0;
        case (sz)
            2'b00:   return w;
            2'b01:   return {16'h0000, sh[15:0]};
            default: return {24'h000000, sh[7:0]};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state       = state;
        data_mem_ready_n = 1'b1;
        access_err       = 1'b0;
        case (state)
            IDLE: if (require_mem_access) next_state = (WAIT_CYCLES != 0) ? WAIT : RESP;
            WAIT: begin
                if (!require_mem_access)  next_state = IDLE;
                else if (wait_cnt == 4'd1) next_state = RESP;
            end
            RESP: begin
                next_state       = IDLE;
                data_mem_ready_n = 1'b0;
                access_err       = is_improper(req_size, req_addr[1:0]);
            end
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states the request is latched on the same edge that enters RESP,
    // so the load path must take the request straight from the ports while in IDLE.
    always_comb begin
        cur_addr  = req_addr;
        cur_write = req_write;
        cur_size  = req_size;
        if (state == IDLE) begin
            cur_addr  = addr[AW-1:0];
            cur_write = write;
            cur_size  = size;
        end
    end

    always_comb begin
        byte_en = 4'b1111;
        wr_data = req_data;
        case (req_size)
            2'b01: begin
                byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_data[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_data[7:0]}};
            end
            default: ;
        endcase
        mem_we = (state == RESP) && req_write && !is_improper(req_size, req_addr[1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt      <= '0;
            req_addr      <= '0;
            req_write     <= 1'b0;
            req_size      <= '0;
            req_data      <= '0;
            data_from_mem <= '0;
        end else begin
            if (state == IDLE && require_mem_access) begin
                req_addr  <= addr[AW-1:0];
                req_write <= write;
                req_size  <= size;
                req_data  <= data_to_mem;
                wait_cnt  <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                wait_cnt <= require_mem_access ? wait_cnt - 4'd1 : '0;
            end
            if (next_state == RESP && state != RESP && !cur_write)
                data_from_mem <= extract(mem[cur_addr[AW-1:2]], cur_size, cur_addr[1:0]);
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++)
                if (byte_en[i]) mem[req_addr[AW-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// It uses three instances with WAIT_CYCLES set to 0, 1 and 3.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic        wr = 1'b0;
    logic [1:0]  sz = '0;
    logic [31:0] ad = '0;
    logic [31:0] wd = '0;
    logic [2:0]  rdy_n;
    logic [2:0]  err;
    logic [31:0] dout [3];

    int checks = 0;
    int failures = 0;
    int lat;
    int lows;
    logic [31:0] rd;
    logic        e;

    always #5 clk = ~clk;

    data_mem_responder #(.WORD_ADDR_BITS(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .require_mem_access(req[0]), .write(wr), .size(sz), .addr(ad),
        .data_to_mem(wd), .data_mem_ready_n(rdy_n[0]), .data_from_mem(dout[0]), .access_err(err[0]));
    data_mem_responder #(.WORD_ADDR_BITS(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .require_mem_access(req[1]), .write(wr), .size(sz), .addr(ad),
        .data_to_mem(wd), .data_mem_ready_n(rdy_n[1]), .data_from_mem(dout[1]), .access_err(err[1]));
    data_mem_responder #(.WORD_ADDR_BITS(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .require_mem_access(req[2]), .write(wr), .size(sz), .addr(ad),
        .data_to_mem(wd), .data_mem_ready_n(rdy_n[2]), .data_from_mem(dout[2]), .access_err(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access on instance d; inputs are scrambled after acceptance.
    task automatic do_access(input int d, input logic w, input logic [1:0] s,
                             input logic [31:0] a, input logic [31:0] data,
                             output int latency, output logic [31:0] rdata, output logic rerr);
        @(negedge clk);
        wr = w; sz = s; ad = a; wd = data; req[d] = 1'b1;
        latency = 0;
        while (latency < 40) begin
            @(posedge clk); #1;
            latency++;
            if (latency == 1) begin
                wr = ~w; sz = 2'b11; ad = 32'hFFFF_FFFC; wd = 32'h0;
            end
            if (rdy_n[d] == 1'b0) break;
        end
        rdata = dout[d];
        rerr  = err[d];
        req[d] = 1'b0;
        @(posedge clk); #1;
        check("ready_single_cycle", {31'b0, rdy_n[d]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_ready_n", {29'b0, rdy_n}, 32'h7);
        check("rst_dout", dout[1], 32'h0);
        check("rst_err", {29'b0, err}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // WAIT_CYCLES=1 instance: word, byte and half accesses
        do_access(1, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, lat, rd, e);
        check("wr_word_lat", lat, 2);
        check("wr_word_err", {31'b0, e}, 0);
        check("wr_dout_unchanged", rd, 32'h0);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        check("rd_word_lat", lat, 2);
        check("rd_word_data", rd, 32'hDEADBEEF);
        check("rd_word_err", {31'b0, e}, 0);

        do_access(1, 1'b1, 2'b10, 32'h13, 32'h0000005A, lat, rd, e);
        check("wr_byte_dout_held", rd, 32'hDEADBEEF);
        do_access(1, 1'b1, 2'b01, 32'h10, 32'h00001234, lat, rd, e);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        check("rd_word_merged", rd, 32'h5AAD1234);
        do_access(1, 1'b0, 2'b10, 32'h13, 32'h0, lat, rd, e);
        check("rd_byte_lane3", rd, 32'h0000005A);
        do_access(1, 1'b0, 2'b01, 32'h12, 32'h0, lat, rd, e);
        check("rd_half_upper", rd, 32'h00005AAD);

        // improper and misaligned accesses
        do_access(1, 1'b1, 2'b00, 32'h12, 32'hFFFFFFFF, lat, rd, e);
        check("misalign_wr_lat", lat, 2);
        check("misalign_wr_err", {31'b0, e}, 1);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        check("misalign_no_write", rd, 32'h5AAD1234);
        check("aligned_err_clear", {31'b0, e}, 0);
        do_access(1, 1'b0, 2'b11, 32'h10, 32'h0, lat, rd, e);
        check("size11_data", rd, 32'h0);
        check("size11_err", {31'b0, e}, 1);
        do_access(1, 1'b0, 2'b01, 32'h11, 32'h0, lat, rd, e);
        check("half_odd_err", {31'b0, e}, 1);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        check("rd_before_reset", rd, 32'h5AAD1234);

        // reset in the middle of a write's wait state
        @(negedge clk);
        wr = 1'b1; sz = 2'b00; ad = 32'h10; wd = 32'hCAFEF00D; req[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) rst = 1'b1;
        #1;
        check("midrst_ready_n", {31'b0, rdy_n[1]}, 1);
        check("midrst_dout", dout[1], 32'h0);
        check("midrst_err", {31'b0, err[1]}, 0);
        req[1] = 1'b0;
        @(negedge clk) rst = 1'b0;
        lows = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy_n[1] == 1'b0) lows++;
        end
        check("midrst_no_ready", lows, 0);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
        check("midrst_no_write", rd, 32'h5AAD1234);
        do_access(1, 1'b0, 2'b10, 32'h13, 32'h0, lat, rd, e);
        check("rst_keeps_storage", rd, 32'h0000005A);

        // WAIT_CYCLES=3 instance: flush
        do_access(2, 1'b1, 2'b00, 32'h20, 32'h11223344, lat, rd, e);
        check("w3_wr_lat", lat, 4);
        @(negedge clk);
        wr = 1'b1; sz = 2'b00; ad = 32'h20; wd = 32'hAAAAAAAA; req[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        lows = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy_n[2] == 1'b0) lows++;
        end
        check("flush_no_ready", lows, 0);
        do_access(2, 1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
        check("flush_rd_lat", lat, 4);
        check("flush_no_write", rd, 32'h11223344);

        // WAIT_CYCLES=0 instance: back-to-back write then wrapped read
        @(negedge clk);
        wr = 1'b1; sz = 2'b00; ad = 32'h0; wd = 32'h0BADF00D; req[0] = 1'b1;
        @(posedge clk); #1;
        check("b2b_wr_ready", {31'b0, rdy_n[0]}, 0);
        wr = 1'b0; ad = 32'h1000; wd = 32'h0;
        @(posedge clk); #1;
        check("b2b_gap", {31'b0, rdy_n[0]}, 1);
        @(posedge clk); #1;
        check("b2b_rd_ready", {31'b0, rdy_n[0]}, 0);
        check("wrap_rd_data", dout[0], 32'h0BADF00D);
        check("wrap_rd_err", {31'b0, err[0]}, 0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_ready", {31'b0, rdy_n[0]}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
